// File: rtl/motoro3_step_scheduler.sv
// Commutation-step scheduler for the 3-phase motor datapath: step-period counter, end-of-period
// strobes, 12-step sector index and soft-start/soft-stop ramping of the PWM pulse length.
module motoro3_step_scheduler #(
  parameter int CNT_W    = 25,
  parameter int STEP_NUM = 12,
  parameter int PER_MIN  = 2
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             enable,
  input  logic             dirRev,
  input  logic [CNT_W-1:0] periodWant,
  input  logic [15:0]      plLenTarget,
  input  logic [15:0]      rampStep,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntLast2,
  output logic             m3cntLast1,
  output logic [3:0]       sgStep,
  output logic [15:0]      plLen,
  output logic             running,
  output logic             stepTick,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PER_MIN_V = CNT_W'(PER_MIN);
  localparam logic [3:0]       STEP_LAST = 4'(STEP_NUM - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt, period_m1;
  logic [3:0]       step_nxt, step_adv;
  logic [15:0]      pl_nxt, goal, pl_moved;
  logic [16:0]      pl_sum, pl_diff;
  logic             tick_nxt, boundary;

  assign boundary   = (state != IDLE) && (m3cnt == '0);
  assign m3cntLast1 = boundary;
  assign m3cntLast2 = (state != IDLE) && (m3cnt == CNT_W'(1));
  assign running    = (state == RAMP) || (state == RUN);
  assign dbg_state  = state;

  assign period_m1 = ((periodWant < PER_MIN_V) ? PER_MIN_V : periodWant) - CNT_W'(1);

  always_comb begin
    step_adv = sgStep;
    if (dirRev) step_adv = (sgStep == 4'd0) ? STEP_LAST : sgStep - 4'd1;
    else        step_adv = (sgStep == STEP_LAST) ? 4'd0 : sgStep + 4'd1;
  end

  // A falling enable already aims at zero in the same boundary clock it is seen in.
  always_comb begin
    goal     = (enable && (state != IDLE)) ? plLenTarget : 16'd0;
    pl_sum   = {1'b0, plLen} + {1'b0, rampStep};
    pl_diff  = {1'b0, plLen} - {1'b0, rampStep};
    pl_moved = goal;
    if (rampStep == 16'd0) begin
      pl_moved = goal;
    end else if (plLen < goal) begin
      pl_moved = (pl_sum >= {1'b0, goal}) ? goal : pl_sum[15:0];
    end else if (plLen > goal) begin
      pl_moved = (pl_diff[16] || (pl_diff[15:0] <= goal)) ? goal : pl_diff[15:0];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = m3cnt;
    step_nxt  = sgStep;
    pl_nxt    = plLen;
    tick_nxt  = 1'b0;
    if (state == IDLE) begin
      pl_nxt  = 16'd0;
      cnt_nxt = '0;
      if (enable) begin
        state_nxt = RAMP;
        cnt_nxt   = period_m1;
      end
    end else begin
      cnt_nxt = boundary ? period_m1 : m3cnt - CNT_W'(1);
      if (boundary) begin
        step_nxt = step_adv;
        tick_nxt = 1'b1;
        pl_nxt   = pl_moved;
      end
      case (state)
        RAMP: begin
          if (!enable) state_nxt = STOP;
          else if (boundary && (pl_moved == plLenTarget)) state_nxt = RUN;
        end
        RUN: begin
          if (!enable) state_nxt = STOP;
          else if (boundary && (plLenTarget != plLen)) state_nxt = RAMP;
        end
        STOP: begin
          if (enable) begin
            state_nxt = RAMP;
          end else if (boundary && (pl_moved == 16'd0)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The PWM datapath samples on posedge, so all state moves on negedge.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      m3cnt    <= '0;
      sgStep   <= 4'd0;
      plLen    <= 16'd0;
      stepTick <= 1'b0;
    end else begin
      state    <= state_nxt;
      m3cnt    <= cnt_nxt;
      sgStep   <= step_nxt;
      plLen    <= pl_nxt;
      stepTick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_motoro3_step_scheduler.sv
// Directed bench for motoro3_step_scheduler: a per-clock vector table plus hand-written
// sequences for soft-start, soft-stop, direction reversal, 17-bit ramp limits and reset.
module tb_motoro3_step_scheduler;

  localparam int CNT_W = 25;

  logic             clk;
  logic             nRst;
  logic             enable;
  logic             dirRev;
  logic [CNT_W-1:0] periodWant;
  logic [15:0]      plLenTarget;
  logic [15:0]      rampStep;
  logic [CNT_W-1:0] m3cnt;
  logic             m3cntLast2;
  logic             m3cntLast1;
  logic [3:0]       sgStep;
  logic [15:0]      plLen;
  logic             running;
  logic             stepTick;
  logic [1:0]       dbg_state;

  int n_cmp;
  int n_err;

  motoro3_step_scheduler dut (
    .clk(clk), .nRst(nRst), .enable(enable), .dirRev(dirRev),
    .periodWant(periodWant), .plLenTarget(plLenTarget), .rampStep(rampStep),
    .m3cnt(m3cnt), .m3cntLast2(m3cntLast2), .m3cntLast1(m3cntLast1),
    .sgStep(sgStep), .plLen(plLen), .running(running), .stepTick(stepTick),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  typedef struct {
    logic             en;
    logic             dir;
    logic [CNT_W-1:0] pw;
    logic [15:0]      tgt;
    logic [15:0]      rs;
    logic [CNT_W-1:0] cnt;
    logic             l2;
    logic             l1;
    logic [3:0]       sg;
    logic [15:0]      pl;
    logic             run;
    logic             tick;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic dir, input logic [CNT_W-1:0] pw,
                       input logic [15:0] tgt, input logic [15:0] rs);
    enable      = en;
    dirRev      = dir;
    periodWant  = pw;
    plLenTarget = tgt;
    rampStep    = rs;
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    drive(1'b0, 1'b0, '0, 16'd0, 16'd0);
    repeat (2) @(posedge clk);
    nRst = 1'b1;
  endtask

  task automatic wait_tick(input int max_clk, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!stepTick && n < max_clk);
    if (!stepTick) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no stepTick within %0d clocks", name, max_clk);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nRst  = 1'b0;
    drive(1'b0, 1'b0, '0, 16'd0, 16'd0);

    // reset values
    do_reset();
    #1;
    check("rst_cnt", 32'(m3cnt), 32'd0);
    check("rst_sg", 32'(sgStep), 32'd0);
    check("rst_pl", 32'(plLen), 32'd0);
    check("rst_run", 32'(running), 32'd0);
    check("rst_tick", 32'(stepTick), 32'd0);
    check("rst_l1", 32'(m3cntLast1), 32'd0);
    check("rst_l2", 32'(m3cntLast2), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // per-clock table: clamped period 2, soft-start 20/step, reverse, soft-stop in a boundary clock
    vt[0]  = '{1'b1, 1'b0, 25'd0, 16'd50, 16'd20, 25'd1, 1'b1, 1'b0, 4'd0,  16'd0,  1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 25'd0, 16'd50, 16'd20, 25'd0, 1'b0, 1'b1, 4'd0,  16'd0,  1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 25'd0, 16'd50, 16'd20, 25'd1, 1'b1, 1'b0, 4'd1,  16'd20, 1'b1, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 25'd1, 16'd50, 16'd20, 25'd0, 1'b0, 1'b1, 4'd1,  16'd20, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 25'd1, 16'd50, 16'd20, 25'd1, 1'b1, 1'b0, 4'd2,  16'd40, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 25'd1, 16'd50, 16'd20, 25'd0, 1'b0, 1'b1, 4'd2,  16'd40, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 25'd1, 16'd50, 16'd20, 25'd1, 1'b1, 1'b0, 4'd3,  16'd50, 1'b1, 1'b1};
    vt[7]  = '{1'b1, 1'b1, 25'd1, 16'd50, 16'd20, 25'd0, 1'b0, 1'b1, 4'd3,  16'd50, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 25'd1, 16'd50, 16'd20, 25'd1, 1'b1, 1'b0, 4'd2,  16'd50, 1'b1, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 25'd1, 16'd50, 16'd20, 25'd0, 1'b0, 1'b1, 4'd2,  16'd50, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 25'd1, 16'd50, 16'd20, 25'd1, 1'b1, 1'b0, 4'd1,  16'd30, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b1, 25'd1, 16'd50, 16'd20, 25'd0, 1'b0, 1'b1, 4'd1,  16'd30, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 25'd1, 16'd50, 16'd20, 25'd1, 1'b1, 1'b0, 4'd0,  16'd10, 1'b0, 1'b1};
    vt[13] = '{1'b0, 1'b1, 25'd1, 16'd50, 16'd20, 25'd0, 1'b0, 1'b1, 4'd0,  16'd10, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b1, 25'd1, 16'd50, 16'd20, 25'd0, 1'b0, 1'b0, 4'd11, 16'd0,  1'b0, 1'b1};
    vt[15] = '{1'b0, 1'b1, 25'd1, 16'd50, 16'd20, 25'd0, 1'b0, 1'b0, 4'd11, 16'd0,  1'b0, 1'b0};

    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].en, vt[i].dir, vt[i].pw, vt[i].tgt, vt[i].rs);
      @(posedge clk);
      check($sformatf("vec%0d_cnt", i), 32'(m3cnt), 32'(vt[i].cnt));
      check($sformatf("vec%0d_l2", i), 32'(m3cntLast2), 32'(vt[i].l2));
      check($sformatf("vec%0d_l1", i), 32'(m3cntLast1), 32'(vt[i].l1));
      check($sformatf("vec%0d_sg", i), 32'(sgStep), 32'(vt[i].sg));
      check($sformatf("vec%0d_pl", i), 32'(plLen), 32'(vt[i].pl));
      check($sformatf("vec%0d_run", i), 32'(running), 32'(vt[i].run));
      check($sformatf("vec%0d_tick", i), 32'(stepTick), 32'(vt[i].tick));
    end

    // period 10, jump to 300, full electrical cycle with wrap, then async reset mid-RUN
    do_reset();
    drive(1'b1, 1'b0, 25'd10, 16'd300, 16'd0);
    for (int j = 1; j <= 135; j++) begin
      int exp_cnt;
      exp_cnt = 9 - ((j - 1) % 10);
      @(posedge clk);
      check($sformatf("p10_cnt_%0d", j), 32'(m3cnt), 32'(exp_cnt));
      check($sformatf("p10_l2_%0d", j), 32'(m3cntLast2), 32'(exp_cnt == 1));
      check($sformatf("p10_l1_%0d", j), 32'(m3cntLast1), 32'(exp_cnt == 0));
      check($sformatf("p10_sg_%0d", j), 32'(sgStep), 32'(((j - 1) / 10) % 12));
      check($sformatf("p10_tick_%0d", j), 32'(stepTick), 32'(j > 1 && (j - 1) % 10 == 0));
      check($sformatf("p10_pl_%0d", j), 32'(plLen), (j >= 11) ? 32'd300 : 32'd0);
    end
    check("p10_state", 32'(dbg_state), 32'd2);
    #10 nRst = 1'b0;
    #1;
    check("amid_cnt", 32'(m3cnt), 32'd0);
    check("amid_sg", 32'(sgStep), 32'd0);
    check("amid_pl", 32'(plLen), 32'd0);
    check("amid_run", 32'(running), 32'd0);
    check("amid_l2", 32'(m3cntLast2), 32'd0);
    enable = 1'b0;
    @(posedge clk);
    nRst = 1'b1;
    @(posedge clk);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("post_rst_sg", 32'(sgStep), 32'd0);

    // reverse direction from step 0
    do_reset();
    drive(1'b1, 1'b1, 25'd3, 16'd0, 16'd0);
    wait_tick(8, "rev_t1");
    check("rev_sg1", 32'(sgStep), 32'd11);
    wait_tick(8, "rev_t2");
    check("rev_sg2", 32'(sgStep), 32'd10);

    // soft-start 300/step to 1000
    do_reset();
    drive(1'b1, 1'b0, 25'd4, 16'd1000, 16'd300);
    for (int k = 0; k < 4; k++) begin
      wait_tick(10, $sformatf("ramp_t%0d", k));
      check($sformatf("ramp_pl%0d", k), 32'(plLen), (k < 3) ? 32'(300 * (k + 1)) : 32'd1000);
      check($sformatf("ramp_st%0d", k), 32'(dbg_state), (k < 3) ? 32'd1 : 32'd2);
    end

    // soft-stop from RUN at 500 by 200/step
    do_reset();
    drive(1'b1, 1'b0, 25'd5, 16'd500, 16'd0);
    wait_tick(10, "stop_start");
    check("stop_pl0", 32'(plLen), 32'd500);
    check("stop_st0", 32'(dbg_state), 32'd2);
    drive(1'b0, 1'b0, 25'd5, 16'd500, 16'd200);
    @(posedge clk);
    check("stop_run", 32'(running), 32'd0);
    check("stop_st1", 32'(dbg_state), 32'd3);
    check("stop_pl1", 32'(plLen), 32'd500);
    for (int k = 0; k < 3; k++) begin
      wait_tick(10, $sformatf("stop_t%0d", k));
      check($sformatf("stop_pl_%0d", k), 32'(plLen), (k == 0) ? 32'd300 : (k == 1) ? 32'd100 : 32'd0);
      check($sformatf("stop_state_%0d", k), 32'(dbg_state), (k < 2) ? 32'd3 : 32'd0);
    end

    // ramps that would wrap a 16-bit sum or difference
    do_reset();
    drive(1'b1, 1'b0, 25'd2, 16'd65535, 16'd40000);
    wait_tick(6, "wide_t0");
    check("wide_up0", 32'(plLen), 32'd40000);
    wait_tick(6, "wide_t1");
    check("wide_up1", 32'(plLen), 32'd65535);
    check("wide_run", 32'(dbg_state), 32'd2);
    enable = 1'b0;
    wait_tick(6, "wide_t2");
    check("wide_dn0", 32'(plLen), 32'd25535);
    wait_tick(6, "wide_t3");
    check("wide_dn1", 32'(plLen), 32'd0);
    check("wide_idle", 32'(dbg_state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
